// File: rtl/connect_four_pkg.sv
// rtl/connect_four_pkg.sv - shared cell/state types and board defaults for connect-four blocks
package connect_four_pkg;

    localparam int DEFAULT_ROWS = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        RED   = 2'b01,
        GREEN = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        PLACE,
        WAIT_ACK,
        RELEASE
    } drop_state_t;

    // Only the two real colours may be dropped; 00 and 11 are refused.
    function automatic logic valid_player(input logic [1:0] p);
        return (p == RED) || (p == GREEN);
    endfunction

endpackage

// File: rtl/column_drop_ctrl_if.sv
// rtl/column_drop_ctrl_if.sv - column drop controller bus: key/player/cell inputs and place/status outputs
interface column_drop_ctrl_if
    import connect_four_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS
);

    logic                  key;
    logic [1:0]            player;
    logic [2*ROWS-1:0]     cells;
    logic [ROWS-1:0]       place;
    logic [1:0]            color;
    logic                  busy;
    logic                  done;
    logic                  reject;
    logic                  err;
    logic                  full;

    // Controller side: consumes key/player/cells, drives the cell write and status.
    modport master (
        input  key,
        input  player,
        input  cells,
        output place,
        output color,
        output busy,
        output done,
        output reject,
        output err,
        output full
    );

    // Board side: drives key/player/cells, observes the controller.
    modport slave (
        output key,
        output player,
        output cells,
        input  place,
        input  color,
        input  busy,
        input  done,
        input  reject,
        input  err,
        input  full
    );

endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - key press detector; debounced when COLUMN_DROP_DEBOUNCE_EN is defined
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic press
);

`ifdef COLUMN_DROP_DEBOUNCE_EN

    // The count saturates one past the fire point so a held key fires exactly once.
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [CNT_W-1:0]  CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive high cycles; any low cycle restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (!key) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Reset to saturated so a key held through reset must be released before it counts.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= CNT_SAT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign press = key && (cnt_q == CNT_FIRE);

`else

    logic key_q;
    logic unused_debounce;

    // Previous key level; reset to 1 so a key held through reset does not look like a new edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_q <= 1'b1;
        end else begin
            key_q <= key;
        end
    end

    assign press           = key && !key_q;
    assign unused_debounce = |DEBOUNCE_CYCLES;

`endif

endmodule

// File: rtl/column_drop_ctrl.sv
// rtl/column_drop_ctrl.sv - per-column drop controller; optional press debounce via COLUMN_DROP_DEBOUNCE_EN
module column_drop_ctrl
    import connect_four_pkg::*;
#(
    parameter int ROWS            = DEFAULT_ROWS,
    parameter int ACK_TIMEOUT     = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic               clock,
    input  logic               reset,
    column_drop_ctrl_if.master bus
);

    localparam int               RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int               CW        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]    ACK_LIMIT = CW'(ACK_TIMEOUT);
    localparam logic [ROWS-1:0]  ROW0      = ROWS'(1);

    drop_state_t      state_q;
    drop_state_t      state_d;
    logic [RW-1:0]    target_q;
    logic [RW-1:0]    target_d;
    logic [1:0]       color_lat_q;
    logic [1:0]       color_lat_d;
    logic [CW-1:0]    ack_cnt_q;
    logic [CW-1:0]    ack_cnt_d;

    logic [ROWS-1:0]  place_q;
    logic [ROWS-1:0]  place_d;
    logic [1:0]       color_q;
    logic [1:0]       color_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             reject_q;
    logic             reject_d;
    logic             err_q;
    logic             err_d;

    logic             press;
    logic             col_full;
    logic [RW-1:0]    target_row;
    logic [1:0]       target_cell;

    key_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_conditioner (
        .clock (clock),
        .reset (reset),
        .key   (bus.key),
        .press (press)
    );

    assign col_full    = bus.cells[2*(ROWS-1) +: 2] != EMPTY;
    assign target_cell = bus.cells[2*target_q +: 2];

    // Lowest empty row: scan top-down so the last hit (the lowest row) wins.
    always_comb begin
        target_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (bus.cells[2*r +: 2] == EMPTY) begin
                target_row = RW'(r);
            end
        end
    end

    // Drop sequencing plus registered output decode from the next state.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        color_lat_d = color_lat_q;
        ack_cnt_d   = ack_cnt_q;
        done_d      = 1'b0;
        reject_d    = 1'b0;
        err_d       = 1'b0;
        place_d     = '0;
        color_d     = EMPTY;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                ack_cnt_d = '0;
                if (press) begin
                    if (!valid_player(bus.player) || col_full) begin
                        reject_d = 1'b1;
                        state_d  = RELEASE;
                    end else begin
                        target_d    = target_row;
                        color_lat_d = bus.player;
                        state_d     = PLACE;
                    end
                end
            end
            PLACE: begin
                ack_cnt_d = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Only the target cell is watched; an ack on the last counted cycle still wins.
                ack_cnt_d = ack_cnt_q + 1'b1;
                if (target_cell == color_lat_q) begin
                    done_d    = 1'b1;
                    ack_cnt_d = '0;
                    state_d   = RELEASE;
                end else if (ack_cnt_d == ACK_LIMIT) begin
                    err_d     = 1'b1;
                    ack_cnt_d = '0;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.key) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            PLACE: begin
                place_d = ROW0 << target_d;
                color_d = color_lat_d;
                busy_d  = 1'b1;
            end
            WAIT_ACK: begin
                color_d = color_lat_d;
                busy_d  = 1'b1;
            end
            default: begin
                place_d = '0;
            end
        endcase
    end

    // State, latched operands and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            color_lat_q <= EMPTY;
            ack_cnt_q   <= '0;
            place_q     <= '0;
            color_q     <= EMPTY;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            color_lat_q <= color_lat_d;
            ack_cnt_q   <= ack_cnt_d;
            place_q     <= place_d;
            color_q     <= color_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            reject_q    <= reject_d;
            err_q       <= err_d;
        end
    end

    assign bus.place  = place_q;
    assign bus.color  = color_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.reject = reject_q;
    assign bus.err    = err_q;
    assign bus.full   = col_full;

endmodule

// File: tb/tb_column_drop_ctrl.sv
// tb/tb_column_drop_ctrl.sv - self-checking bench for column_drop_ctrl
module tb_column_drop_ctrl;
    import connect_four_pkg::*;

    localparam int ROWS        = 6;
    localparam int ACK_TIMEOUT = 4;
`ifdef COLUMN_DROP_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif

    typedef struct {
        logic [1:0]      pl;
        int              prefill;
        int              hold;
        bit              ack;
        int              pl_off;
        logic [ROWS-1:0] place;
        int              done;
        int              err;
        int              rej;
        int              busy;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [1:0] col_q[$];
    vec_t vecs[9];

    column_drop_ctrl_if #(.ROWS(ROWS)) bus ();

    column_drop_ctrl #(
        .ROWS            (ROWS),
        .ACK_TIMEOUT     (ACK_TIMEOUT),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input string sig, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s at cycle %0d: got %0h expected %0h", tag, sig, k, act, exp);
        end
    endtask

    function automatic bit hit(input int e, input int k);
        return (e >= 0) && (k == e + DB);
    endfunction

    function automatic logic [2*ROWS-1:0] build_cells();
        logic [2*ROWS-1:0] v;
        v = '0;
        for (int i = 0; i < col_q.size(); i++) v[2*i +: 2] = col_q[i];
        return v;
    endfunction

    task automatic set_column(input int n);
        col_q.delete();
        for (int i = 0; i < n; i++) col_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
        bus.cells = build_cells();
        tick();
        tick();
    endtask

    // Transaction-level expectation from the column occupancy and the drop rules.
    task automatic expect_op(input logic [1:0] pl, input bit ack,
                             output int pl_off, output logic [ROWS-1:0] place,
                             output int done, output int err, output int rej, output int busy);
        logic [ROWS-1:0] one;
        one = 1;
        pl_off = -1; place = '0; done = -1; err = -1; rej = -1; busy = 0;
        if ((pl == 2'b01 || pl == 2'b10) && col_q.size() < ROWS) begin
            pl_off = 1;
            place  = one << col_q.size();
            if (ack) begin
                done = pl_off + 2;
            end else begin
                err = pl_off + 1 + ACK_TIMEOUT;
            end
            busy = ((done >= 0) ? done : err) - 1;
        end else begin
            rej = 1;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] pl, input int hold, input bit ack,
                          input bit scramble, input int e_pl_off, input logic [ROWS-1:0] e_place,
                          input int e_done, input int e_err, input int e_rej, input int e_busy);
        int   h;
        int   w;
        int   ack_at;
        logic in_busy;
        h      = hold + DB;
        w      = ((h > 7 + DB) ? h : 7 + DB) + 3;
        ack_at = -1;
        for (int k = 0; k < w; k++) begin
            tick();
            in_busy = (e_busy > 0) && (k >= 1 + DB) && (k <= e_busy + DB);
            check(tag, "place",  k, 32'(bus.place),  hit(e_pl_off, k) ? 32'(e_place) : 32'd0);
            check(tag, "color",  k, 32'(bus.color),  in_busy ? 32'(pl) : 32'd0);
            check(tag, "busy",   k, 32'(bus.busy),   32'(in_busy));
            check(tag, "done",   k, 32'(bus.done),   32'(hit(e_done, k)));
            check(tag, "err",    k, 32'(bus.err),    32'(hit(e_err, k)));
            check(tag, "reject", k, 32'(bus.reject), 32'(hit(e_rej, k)));
            if (ack && ack_at < 0 && bus.place != '0) ack_at = k + 1;
            if (k == ack_at) col_q.push_back(pl);
            bus.key    = (k < h);
            bus.player = (scramble && k > DB) ? 2'($urandom_range(0, 3)) : pl;
            bus.cells  = build_cells();
            #1;
            check(tag, "full", k, 32'(bus.full), 32'(col_q.size() == ROWS));
        end
        bus.key = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b01, 0,  1, 1'b1,  1, 6'b000001,  3, -1, -1, 2};
        vecs[1] = '{2'b10, 3,  1, 1'b1,  1, 6'b001000,  3, -1, -1, 2};
        vecs[2] = '{2'b01, 6, 10, 1'b1, -1, 6'b000000, -1, -1,  1, 0};
        vecs[3] = '{2'b00, 0,  1, 1'b1, -1, 6'b000000, -1, -1,  1, 0};
        vecs[4] = '{2'b11, 2,  3, 1'b1, -1, 6'b000000, -1, -1,  1, 0};
        vecs[5] = '{2'b10, 0,  2, 1'b0,  1, 6'b000001, -1,  6, -1, 5};
        vecs[6] = '{2'b01, 0, 20, 1'b1,  1, 6'b000001,  3, -1, -1, 2};
        vecs[7] = '{2'b10, 5,  1, 1'b1,  1, 6'b100000,  3, -1, -1, 2};
        vecs[8] = '{2'b01, 1, 15, 1'b0,  1, 6'b000010, -1,  6, -1, 5};

        reset      = 1'b1;
        bus.key    = 1'b0;
        bus.player = 2'b00;
        bus.cells  = '0;
        repeat (3) tick();
        check("reset", "place",  0, 32'(bus.place),  32'd0);
        check("reset", "color",  0, 32'(bus.color),  32'd0);
        check("reset", "busy",   0, 32'(bus.busy),   32'd0);
        check("reset", "done",   0, 32'(bus.done),   32'd0);
        check("reset", "reject", 0, 32'(bus.reject), 32'd0);
        check("reset", "err",    0, 32'(bus.err),    32'd0);
        check("reset", "full",   0, 32'(bus.full),   32'd0);
        reset = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 9; i++) begin
            set_column(vecs[i].prefill);
            run_op($sformatf("vec%0d", i), vecs[i].pl, vecs[i].hold, vecs[i].ack, 1'b0,
                   vecs[i].pl_off, vecs[i].place, vecs[i].done, vecs[i].err, vecs[i].rej, vecs[i].busy);
        end

        // Reset while waiting for the ack, key held throughout: no new press afterwards.
        set_column(0);
        for (int k = 0; k < 12 + DB; k++) begin
            tick();
            if (k == 1 + DB) check("rst_mid", "place", k, 32'(bus.place), 32'd1);
            if (k == 3 + DB) begin
                check("rst_mid", "place",  k, 32'(bus.place),  32'd0);
                check("rst_mid", "color",  k, 32'(bus.color),  32'd0);
                check("rst_mid", "busy",   k, 32'(bus.busy),   32'd0);
                check("rst_mid", "done",   k, 32'(bus.done),   32'd0);
                check("rst_mid", "reject", k, 32'(bus.reject), 32'd0);
                check("rst_mid", "err",    k, 32'(bus.err),    32'd0);
            end
            if (k > 3 + DB) begin
                check("rst_held", "place", k, 32'(bus.place), 32'd0);
                check("rst_held", "busy",  k, 32'(bus.busy),  32'd0);
                check("rst_held", "err",   k, 32'(bus.err),   32'd0);
            end
            bus.key    = 1'b1;
            bus.player = 2'b01;
            reset      = (k == 2 + DB);
        end
        bus.key = 1'b0;
        tick();
        tick();
        run_op("rst_recover", 2'b01, 1, 1'b1, 1'b0, 1, 6'b000001, 3, -1, -1, 2);

`ifdef COLUMN_DROP_DEBOUNCE_EN
        set_column(0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("db5", "place", k, 32'(bus.place), 32'd0);
            bus.key    = (k < 5);
            bus.player = 2'b01;
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            check("db10", "place", k, 32'(bus.place), (k == 9) ? 32'd1 : 32'd0);
            bus.key    = (k < 10);
            bus.player = 2'b01;
        end
        bus.key = 1'b0;
        tick();
        tick();
`endif

        for (int n = 0; n < 120; n++) begin
            logic [1:0]      pl;
            int              hold;
            bit              ack;
            int              e_pl_off;
            logic [ROWS-1:0] e_place;
            int              e_done;
            int              e_err;
            int              e_rej;
            int              e_busy;
            if ($urandom_range(0, 7) == 0) set_column($urandom_range(0, ROWS));
            if ($urandom_range(0, 3) == 0) pl = 2'($urandom_range(0, 3));
            else pl = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            hold = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 14) : $urandom_range(1, 3);
            ack  = ($urandom_range(0, 4) != 0);
            expect_op(pl, ack, e_pl_off, e_place, e_done, e_err, e_rej, e_busy);
            run_op("rand", pl, hold, ack, 1'b1, e_pl_off, e_place, e_done, e_err, e_rej, e_busy);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
